jk_universal_reg: RTL
=====================

# jk_universal_reg

Parametrised WIDTH-bit universal register built from per-bit JK flip-flop cells, generalising the single-bit JK-based D flip-flop to a multi-bit register. A 3-bit mode input selects one of hold, parallel load, masked toggle, per-bit JK, shift left/right, clear or set. It is a general-purpose state element for counters, shifters and control registers elsewhere in the design, and it reports on a registered flag whenever its contents change.

## Interface
- WIDTH, 8, register width in bits (≥2)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- en  input  1  update enable; 0 = hold regardless of mode
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  load data (LOAD) or toggle mask (TOGGLE)
- j  input  WIDTH  per-bit J (JK mode)
- k  input  WIDTH  per-bit K (JK mode)
- ser_in  input  1  serial bit shifted in (SHL/SHR)
- q  output  WIDTH  register contents
- qn  output  WIDTH  ~q, combinational from q
- ser_out  output  1  registered bit most recently shifted out
- changed  output  1  registered; 1 when the last edge altered q

## Operation
- Mode codes: 000 HOLD, 001 LOAD, 010 TOGGLE, 011 JK, 100 SHL, 101 SHR, 110 CLEAR, 111 SET.
- HOLD: q unchanged. LOAD: q←d. TOGGLE: q←q^d. JK: per bit, j=0/k=0 hold, 1/0 set, 0/1 clear, 1/1 toggle.
- SHL: q←{q[WIDTH-2:0], ser_in}, ser_out←q[WIDTH-1]. SHR: q←{ser_in, q[WIDTH-1:1]}, ser_out←q[0].
- CLEAR: q←0. SET: q←all ones.
- ser_out updates only on shift operations; otherwise holds.
- changed ← (q_next != q) on every edge; 0 when en=0; 0 on reset edge.
- Every mode is realised by deriving per-bit J/K and driving the jk_cell array; no direct D path around the cells.

## Timing
- All state updates on rising clk; single-cycle latency from inputs to q, ser_out, changed.
- Reset values: q=RESET_VAL, qn=~RESET_VAL, ser_out=0, changed=0.
- rst has priority over en and mode; rst=1 with en=1, LOAD applies reset only.
- en=0: q, ser_out hold; changed=0 on that edge.
- Operation yielding the current value (LOAD of equal data, JK all 0, CLEAR when zero) gives changed=0.
- qn has no extra latency; glitch-free relative to q.
- Reset asserted mid-sequence aborts any operation at that edge; next edge after rst deassert behaves from RESET_VAL.

## Configuration
- JK_UREG_SHIFT_EN defined: SHL/SHR implemented as above, ser_out live.
- Undefined: codes 100/101 act as HOLD (changed=0), ser_in ignored, ser_out tied 0; shift muxing removed from the netlist.

## Structure
- Package jk_ureg_pkg: mode enum/localparams (MODE_HOLD … MODE_SET), mode width constant.
- Sub-module jk_cell: one-bit JK flop with clk, rst, rst_val, j, k, q; instantiated WIDTH times via generate.
- Top level holds the mode decoder (per-bit J/K derivation), ser_out and changed registers.

## Test plan
- Reset: rst=1 for one edge, RESET_VAL=0 -> q=8'h00, qn=8'hFF, ser_out=0, changed=0.
- LOAD d=8'hA5 -> q=8'hA5, qn=8'h5A, changed=1; repeat LOAD 8'hA5 -> changed=0; en=0 with LOAD 8'h3C -> q stays 8'hA5.
- From 8'hA5: TOGGLE d=8'h0F -> 8'hAA; JK j=8'hF0,k=8'h0F -> 8'hF0; JK j=k=8'hFF -> 8'h0F; CLEAR -> 8'h00; SET -> 8'hFF.
- With JK_UREG_SHIFT_EN, from 8'h81: SHL ser_in=1 -> q=8'h03, ser_out=1; SHR ser_in=0 -> q=8'h01, ser_out=1; without macro same stimulus -> q=8'h81, ser_out=0, changed=0.
- Simultaneous rst=1, en=1, mode=SET -> q=RESET_VAL, changed=0; next edge rst=0, SET -> q=8'hFF, changed=1.
- WIDTH=16, RESET_VAL=16'hBEEF: reset -> q=16'hBEEF, qn=16'h4110; TOGGLE d=16'hFFFF -> 16'h4110, changed=1.

Source files
------------

// File: rtl/jk_ureg_pkg.sv
// Shared mode encoding for jk_universal_reg and its users.
package jk_ureg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'b000,
    MODE_LOAD   = 3'b001,
    MODE_TOGGLE = 3'b010,
    MODE_JK     = 3'b011,
    MODE_SHL    = 3'b100,
    MODE_SHR    = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_SET    = 3'b111
  } mode_t;

endpackage

// File: rtl/jk_universal_reg_jk_cell.sv
// One-bit JK flip-flop with synchronous, active-high reset to a per-bit value.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      unique case ({j, k})
        2'b00: q <= q;
        2'b10: q <= 1'b1;
        2'b01: q <= 1'b0;
        2'b11: q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_universal_reg.sv
// WIDTH-bit universal register built from jk_cell flops; every mode is mapped to per-bit J/K.
// Optional shifting (SHL/SHR, ser_out) is built only when JK_UREG_SHIFT_EN is defined.
module jk_universal_reg
  import jk_ureg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  j,
  input  logic [WIDTH-1:0]  k,
  input  logic              ser_in,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              ser_out,
  output logic              changed
);

  logic [WIDTH-1:0] j_bit;
  logic [WIDTH-1:0] k_bit;
  logic [WIDTH-1:0] q_next;

  // Loads of a target value use j=v, k=~v so each cell lands on v regardless of its state.
  always_comb begin
    j_bit = '0;
    k_bit = '0;
    if (en) begin
      case (mode_t'(mode))
        MODE_LOAD: begin
          j_bit = d;
          k_bit = ~d;
        end
        MODE_TOGGLE: begin
          j_bit = d;
          k_bit = d;
        end
        MODE_JK: begin
          j_bit = j;
          k_bit = k;
        end
`ifdef JK_UREG_SHIFT_EN
        MODE_SHL: begin
          j_bit = {q[WIDTH-2:0], ser_in};
          k_bit = ~{q[WIDTH-2:0], ser_in};
        end
        MODE_SHR: begin
          j_bit = {ser_in, q[WIDTH-1:1]};
          k_bit = ~{ser_in, q[WIDTH-1:1]};
        end
`endif
        MODE_CLEAR: begin
          j_bit = '0;
          k_bit = '1;
        end
        MODE_SET: begin
          j_bit = '1;
          k_bit = '0;
        end
        default: begin
          j_bit = '0;
          k_bit = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .j       (j_bit[i]),
      .k       (k_bit[i]),
      .q       (q[i])
    );
  end

  assign qn = ~q;

  // Characteristic JK equation predicts what the cells will hold after this edge.
  assign q_next = (j_bit & ~q) | (~k_bit & q);

  always_ff @(posedge clk) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= (q_next != q);
    end
  end

`ifdef JK_UREG_SHIFT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_out <= 1'b0;
    end else if (en && mode_t'(mode) == MODE_SHL) begin
      ser_out <= q[WIDTH-1];
    end else if (en && mode_t'(mode) == MODE_SHR) begin
      ser_out <= q[0];
    end
  end
`else
  logic unused_ser_in;
  assign unused_ser_in = ser_in;
  assign ser_out       = 1'b0;
`endif

endmodule
